// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the 7-segment scan controller.
//   scan_state_t : scan FSM states (IDLE, BLANK, SHOW)
//   seg_t        : 7-bit segment vector, bit 6 = segment a ... bit 0 = segment g
//   SEG_OFF      : all segments dark
package seven_seg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } scan_state_t;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_OFF = 7'h00;

endpackage

// File: rtl/seven_seg_scan_ctrl_decoder.sv
// Display_7_Seg: combinational hex-to-segment decoder.
//   i_Nibble [3:0] : hex digit 0..F
//   o_Segments [6:0] : active-high segments, bit 6 = a ... bit 0 = g
module Display_7_Seg
    import seven_seg_pkg::*;
(
    input  logic [3:0] i_Nibble,
    output logic [6:0] o_Segments
);

    seg_t seg;

    always_comb begin
        seg = SEG_OFF;
        case (i_Nibble)
            4'h0: seg = 7'h7E;
            4'h1: seg = 7'h30;
            4'h2: seg = 7'h6D;
            4'h3: seg = 7'h79;
            4'h4: seg = 7'h33;
            4'h5: seg = 7'h5B;
            4'h6: seg = 7'h5F;
            4'h7: seg = 7'h70;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h7B;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h1F;
            4'hC: seg = 7'h4E;
            4'hD: seg = 7'h3D;
            4'hE: seg = 7'h4F;
            4'hF: seg = 7'h47;
            default: seg = SEG_OFF;
        endcase
    end

    assign o_Segments = seg;

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-segment 7-segment display.
// Ports:
//   i_Clk, i_Rst       : clock, synchronous active-high reset
//   i_Enable           : scan enable; low forces all outputs off
//   i_DV, i_Data       : load strobe and hex value (digit k = i_Data[4k+3:4k])
//   i_Lz_Blank         : leading-zero blanking enable
//   o_Seg_a..o_Seg_g   : active-high segments
//   o_Dig_En           : one-hot active-high digit select
//   o_Pending          : a loaded value waits for the frame boundary
//   o_Frame            : high on the last SHOW cycle of the last digit
//   o_State            : current scan FSM state (debug)
// Load interface: i_DV is a one-cycle strobe with no back-pressure; every
// strobe is accepted, the newest value overwrites any older pending one, and
// the displayed value only changes at a frame boundary.
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 2,
    parameter int CLKS_PER_DIGIT = 25000,
    parameter int BLANK_CLKS     = 250
) (
    input  logic                    i_Clk,
    input  logic                    i_Rst,
    input  logic                    i_Enable,
    input  logic                    i_DV,
    input  logic [4*NUM_DIGITS-1:0] i_Data,
    input  logic                    i_Lz_Blank,
    output logic                    o_Seg_a,
    output logic                    o_Seg_b,
    output logic                    o_Seg_c,
    output logic                    o_Seg_d,
    output logic                    o_Seg_e,
    output logic                    o_Seg_f,
    output logic                    o_Seg_g,
    output logic [NUM_DIGITS-1:0]   o_Dig_En,
    output logic                    o_Pending,
    output logic                    o_Frame,
    output logic [1:0]              o_State
);

    localparam int CNT_MAX = (CLKS_PER_DIGIT > BLANK_CLKS) ? CLKS_PER_DIGIT : BLANK_CLKS;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int DW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] SHOW_LAST  = CW'(CLKS_PER_DIGIT - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CLKS > 0) ? BLANK_CLKS - 1 : 0);
    localparam logic [DW-1:0] DIG_LAST   = DW'(NUM_DIGITS - 1);

    scan_state_t               state, next_state;
    logic [DW-1:0]             r_Dig, next_dig;
    logic [CW-1:0]             r_Cnt, next_cnt;
    logic [4*NUM_DIGITS-1:0]   r_Disp, r_Pend, next_disp;
    logic                      r_Pend_Valid;
    seg_t                      r_Seg, next_seg;
    logic [NUM_DIGITS-1:0]     r_Dig_En, next_dig_en;
    logic                      frame_last, frame_commit;
    logic [3:0]                dec_nibble;
    logic [6:0]                dec_seg;
    logic [NUM_DIGITS-1:0]     zero_above;

    // Boundary = last SHOW cycle of the last digit. A disable on that same
    // cycle wins, so nothing is committed while the scan is being stopped.
    assign frame_last   = (state == SHOW) && (r_Dig == DIG_LAST) && (r_Cnt == SHOW_LAST);
    assign frame_commit = frame_last && i_Enable;

    always_comb begin
        next_state = state;
        next_dig   = r_Dig;
        next_cnt   = r_Cnt;
        case (state)
            IDLE: begin
                next_dig = '0;
                next_cnt = '0;
                if (i_Enable) next_state = (BLANK_CLKS == 0) ? SHOW : BLANK;
            end
            BLANK: begin
                if (r_Cnt == BLANK_LAST) begin
                    next_state = SHOW;
                    next_cnt   = '0;
                end else begin
                    next_cnt = r_Cnt + 1'b1;
                end
            end
            SHOW: begin
                if (r_Cnt == SHOW_LAST) begin
                    next_cnt   = '0;
                    next_dig   = (r_Dig == DIG_LAST) ? '0 : r_Dig + 1'b1;
                    next_state = (BLANK_CLKS == 0) ? SHOW : BLANK;
                end else begin
                    next_cnt = r_Cnt + 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
        if (!i_Enable) begin
            next_state = IDLE;
            next_dig   = '0;
            next_cnt   = '0;
        end
    end

    // A strobe on the boundary cycle bypasses r_Pend and lands directly.
    always_comb begin
        next_disp = r_Disp;
        if (frame_commit) begin
            if (i_DV)              next_disp = i_Data;
            else if (r_Pend_Valid) next_disp = r_Pend;
        end
    end

    // zero_above[k] is set when nibble k and every nibble above it are zero.
    always_comb begin
        logic acc;
        zero_above = '0;
        acc        = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            acc           = acc && (next_disp[4*k +: 4] == 4'h0);
            zero_above[k] = acc;
        end
    end

    // The decoder sees the value and digit that will be live after this edge,
    // so segments and digit select move together with the state.
    assign dec_nibble = next_disp[4*next_dig +: 4];

    Display_7_Seg u_decoder (
        .i_Nibble   (dec_nibble),
        .o_Segments (dec_seg)
    );

    always_comb begin
        next_seg    = SEG_OFF;
        next_dig_en = '0;
        if (next_state == SHOW) begin
            next_dig_en[next_dig] = 1'b1;
            if (!(i_Lz_Blank && (next_dig != '0) && zero_above[next_dig])) next_seg = dec_seg;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state    <= IDLE;
            r_Dig    <= '0;
            r_Cnt    <= '0;
            r_Seg    <= SEG_OFF;
            r_Dig_En <= '0;
        end else begin
            state    <= next_state;
            r_Dig    <= next_dig;
            r_Cnt    <= next_cnt;
            r_Seg    <= next_seg;
            r_Dig_En <= next_dig_en;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_Disp       <= '0;
            r_Pend       <= '0;
            r_Pend_Valid <= 1'b0;
        end else begin
            r_Disp <= next_disp;
            if (frame_commit) begin
                r_Pend_Valid <= 1'b0;
            end else if (i_DV) begin
                r_Pend       <= i_Data;
                r_Pend_Valid <= 1'b1;
            end
        end
    end

    assign o_Seg_a   = r_Seg[6];
    assign o_Seg_b   = r_Seg[5];
    assign o_Seg_c   = r_Seg[4];
    assign o_Seg_d   = r_Seg[3];
    assign o_Seg_e   = r_Seg[2];
    assign o_Seg_f   = r_Seg[1];
    assign o_Seg_g   = r_Seg[0];
    assign o_Dig_En  = r_Dig_En;
    assign o_Pending = r_Pend_Valid;
    assign o_Frame   = frame_last;
    assign o_State   = state;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
module tb_seven_seg_scan_ctrl;

    localparam int ND    = 2;
    localparam int CPD   = 8;
    localparam int BLK   = 2;
    localparam int DIG_P = BLK + CPD;
    localparam int FRAME = ND * DIG_P;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       dv = 1'b0;
    logic       lz = 1'b0;
    logic [7:0] data = 8'h00;

    logic seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g;
    logic [1:0] dig_en;
    logic       pending, frame;
    logic [1:0] state_dbg;
    logic [6:0] seg_v;

    assign seg_v = {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g};

    seven_seg_scan_ctrl #(
        .NUM_DIGITS     (ND),
        .CLKS_PER_DIGIT (CPD),
        .BLANK_CLKS     (BLK)
    ) dut (
        .i_Clk      (clk),
        .i_Rst      (rst),
        .i_Enable   (en),
        .i_DV       (dv),
        .i_Data     (data),
        .i_Lz_Blank (lz),
        .o_Seg_a    (seg_a),
        .o_Seg_b    (seg_b),
        .o_Seg_c    (seg_c),
        .o_Seg_d    (seg_d),
        .o_Seg_e    (seg_e),
        .o_Seg_f    (seg_f),
        .o_Seg_g    (seg_g),
        .o_Dig_En   (dig_en),
        .o_Pending  (pending),
        .o_Frame    (frame),
        .o_State    (state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: cycles since enable, shown value, pending value
    int         m_c = -1;
    logic [7:0] m_disp = 8'h00;
    logic [7:0] m_pend = 8'h00;
    logic       m_pv = 1'b0;
    logic [6:0] e_seg;
    logic [1:0] e_dig;
    logic       e_frame, e_pend;

    function automatic logic [6:0] hex_seg(input logic [3:0] h);
        logic [6:0] tbl [16];
        tbl = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
        return tbl[h];
    endfunction

    function automatic logic [10:0] actual_v();
        return {seg_v, dig_en, frame, pending};
    endfunction

    function automatic logic [10:0] expected_v();
        return {e_seg, e_dig, e_frame, e_pend};
    endfunction

    // advance one clock and update the model from the inputs seen at the edge
    task automatic tick();
        int   pos, dig;
        logic bnd;
        @(posedge clk);
        if (rst) begin
            m_c = -1; m_disp = 8'h00; m_pend = 8'h00; m_pv = 1'b0;
        end else begin
            bnd = en && (m_c >= 0) && ((m_c % FRAME) == FRAME - 1);
            if (bnd) begin
                if (dv) m_disp = data;
                else if (m_pv) m_disp = m_pend;
                m_pv = 1'b0;
            end else if (dv) begin
                m_pend = data;
                m_pv   = 1'b1;
            end
            m_c = en ? m_c + 1 : -1;
        end
        e_seg   = 7'h00;
        e_dig   = 2'b00;
        e_pend  = m_pv;
        e_frame = (m_c >= 0) && ((m_c % FRAME) == FRAME - 1);
        if (m_c >= 0) begin
            pos = m_c % FRAME;
            dig = pos / DIG_P;
            if ((pos % DIG_P) >= BLK) begin
                e_dig = 2'(1 << dig);
                if (!(lz && dig > 0 && (m_disp >> (4 * dig)) == 8'h00))
                    e_seg = hex_seg(m_disp[4*dig +: 4]);
            end
        end
        @(negedge clk);
    endtask

    task automatic wait_pos(input int p);
        for (int i = 0; i < 3 * FRAME; i++) begin
            tick();
            if (m_c >= 0 && (m_c % FRAME) == p) return;
        end
        n_checks++; n_fail++;
        $display("FAIL wait_pos: position %0d not reached (m_c=%0d)", p, m_c);
    endtask

    task automatic load(input logic [7:0] v);
        dv = 1'b1; data = v;
        tick();
        dv = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; dv = 1'b1; data = 8'hFF;
        tick(); tick(); tick();
        dv = 1'b0;
        rst = 1'b0;
        tick();
        n_checks++;
        if (actual_v() !== 11'h000 || state_dbg !== 2'd0) begin
            n_fail++;
            $display("FAIL reset: outs=%h state=%0d want 000/0", actual_v(), state_dbg);
        end
    endtask

    task automatic test_basic_scan();
        int last_f, n_f;
        load(8'hA5);
        n_checks++;
        if (pending !== 1'b1 || dig_en !== 2'b00) begin
            n_fail++; $display("FAIL idle_load: pend=%b dig=%b want 1/00", pending, dig_en);
        end
        en = 1'b1;
        last_f = -1; n_f = 0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            tick();
            n_checks++;
            if (actual_v() !== expected_v()) begin
                n_fail++; $display("FAIL scan cyc %0d: got %h want %h", i, actual_v(), expected_v());
            end
            if (i == 1 || i == 11) begin
                n_checks++;
                if (seg_v !== 7'h00 || dig_en !== 2'b00) begin
                    n_fail++; $display("FAIL dark cyc %0d: seg=%h dig=%b want 00/00", i, seg_v, dig_en);
                end
            end
            if (i == 2) begin
                n_checks++;
                if (seg_v !== 7'h7E || dig_en !== 2'b01) begin
                    n_fail++; $display("FAIL first_frame: seg=%h dig=%b want 7e/01", seg_v, dig_en);
                end
            end
            if (i == FRAME + 2 || i == FRAME + 9) begin
                n_checks++;
                if (seg_v !== 7'h5B || dig_en !== 2'b01) begin
                    n_fail++; $display("FAIL a5_dig0 cyc %0d: seg=%h dig=%b want 5b/01", i, seg_v, dig_en);
                end
            end
            if (i == FRAME + 12 || i == FRAME + 19) begin
                n_checks++;
                if (seg_v !== 7'h77 || dig_en !== 2'b10) begin
                    n_fail++; $display("FAIL a5_dig1 cyc %0d: seg=%h dig=%b want 77/10", i, seg_v, dig_en);
                end
            end
            if (frame === 1'b1) begin
                if (last_f >= 0) begin
                    n_checks++;
                    if (i - last_f != FRAME) begin
                        n_fail++; $display("FAIL frame_period: got %0d want %0d", i - last_f, FRAME);
                    end
                end
                last_f = i; n_f++;
            end
        end
        n_checks++;
        if (n_f != 3) begin
            n_fail++; $display("FAIL frame_count: got %0d want 3", n_f);
        end
    endtask

    task automatic test_mid_frame_load();
        wait_pos(15);
        load(8'h3C);
        n_checks++;
        if (pending !== 1'b1 || seg_v !== 7'h77 || dig_en !== 2'b10) begin
            n_fail++; $display("FAIL mid_load: pend=%b seg=%h dig=%b want 1/77/10", pending, seg_v, dig_en);
        end
        wait_pos(0);
        n_checks++;
        if (pending !== 1'b0) begin
            n_fail++; $display("FAIL mid_clear: pend=%b want 0", pending);
        end
        wait_pos(2);
        n_checks++;
        if (seg_v !== 7'h4E || dig_en !== 2'b01) begin
            n_fail++; $display("FAIL mid_dig0: seg=%h dig=%b want 4e/01", seg_v, dig_en);
        end
        wait_pos(12);
        n_checks++;
        if (seg_v !== 7'h79 || dig_en !== 2'b10) begin
            n_fail++; $display("FAIL mid_dig1: seg=%h dig=%b want 79/10", seg_v, dig_en);
        end
    endtask

    task automatic test_boundary_collision();
        load(8'h11);
        wait_pos(FRAME - 1);
        n_checks++;
        if (frame !== 1'b1 || pending !== 1'b1) begin
            n_fail++; $display("FAIL coll_frame: frame=%b pend=%b want 1/1", frame, pending);
        end
        load(8'h22);
        n_checks++;
        if (pending !== 1'b0) begin
            n_fail++; $display("FAIL coll_pend: pend=%b want 0", pending);
        end
        wait_pos(2);
        n_checks++;
        if (seg_v !== 7'h6D || dig_en !== 2'b01) begin
            n_fail++; $display("FAIL coll_dig0: seg=%h dig=%b want 6d/01", seg_v, dig_en);
        end
        wait_pos(12);
        n_checks++;
        if (seg_v !== 7'h6D || dig_en !== 2'b10) begin
            n_fail++; $display("FAIL coll_dig1: seg=%h dig=%b want 6d/10", seg_v, dig_en);
        end
    endtask

    task automatic test_lz_blank();
        lz = 1'b1;
        load(8'h07);
        wait_pos(2);
        n_checks++;
        if (seg_v !== 7'h70 || dig_en !== 2'b01) begin
            n_fail++; $display("FAIL lz07_dig0: seg=%h dig=%b want 70/01", seg_v, dig_en);
        end
        wait_pos(12);
        n_checks++;
        if (seg_v !== 7'h00 || dig_en !== 2'b10) begin
            n_fail++; $display("FAIL lz07_dig1: seg=%h dig=%b want 00/10", seg_v, dig_en);
        end
        load(8'h00);
        wait_pos(2);
        n_checks++;
        if (seg_v !== 7'h7E || dig_en !== 2'b01) begin
            n_fail++; $display("FAIL lz00_dig0: seg=%h dig=%b want 7e/01", seg_v, dig_en);
        end
        wait_pos(12);
        n_checks++;
        if (seg_v !== 7'h00 || dig_en !== 2'b10) begin
            n_fail++; $display("FAIL lz00_dig1: seg=%h dig=%b want 00/10", seg_v, dig_en);
        end
        lz = 1'b0;
        load(8'h07);
        wait_pos(12);
        n_checks++;
        if (seg_v !== 7'h7E || dig_en !== 2'b10) begin
            n_fail++; $display("FAIL nolz07_dig1: seg=%h dig=%b want 7e/10", seg_v, dig_en);
        end
    endtask

    task automatic test_disable();
        wait_pos(5);
        load(8'h99);
        en = 1'b0;
        tick();
        n_checks++;
        if (actual_v() !== 11'h001) begin
            n_fail++; $display("FAIL disable: outs=%h want 001", actual_v());
        end
        tick(); tick(); tick();
        n_checks++;
        if (actual_v() !== 11'h001) begin
            n_fail++; $display("FAIL disabled_hold: outs=%h want 001", actual_v());
        end
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (actual_v() !== expected_v()) begin
                n_fail++; $display("FAIL reenable cyc %0d: got %h want %h", i, actual_v(), expected_v());
            end
        end
        n_checks++;
        if (seg_v !== 7'h70 || dig_en !== 2'b01) begin
            n_fail++; $display("FAIL reenable_dig0: seg=%h dig=%b want 70/01", seg_v, dig_en);
        end
        wait_pos(2);
        n_checks++;
        if (seg_v !== 7'h7B || pending !== 1'b0) begin
            n_fail++; $display("FAIL reenable_apply: seg=%h pend=%b want 7b/0", seg_v, pending);
        end
    endtask

    task automatic test_back_to_back();
        wait_pos(5);
        load(8'h12);
        load(8'h34);
        wait_pos(2);
        n_checks++;
        if (seg_v !== 7'h33 || dig_en !== 2'b01) begin
            n_fail++; $display("FAIL b2b_dig0: seg=%h dig=%b want 33/01", seg_v, dig_en);
        end
        wait_pos(12);
        n_checks++;
        if (seg_v !== 7'h79 || dig_en !== 2'b10) begin
            n_fail++; $display("FAIL b2b_dig1: seg=%h dig=%b want 79/10", seg_v, dig_en);
        end
    endtask

    task automatic test_reset_mid();
        wait_pos(5);
        load(8'h44);
        rst = 1'b1;
        tick();
        n_checks++;
        if (actual_v() !== 11'h000) begin
            n_fail++; $display("FAIL reset_mid: outs=%h want 000", actual_v());
        end
        rst = 1'b0;
        wait_pos(2);
        n_checks++;
        if (seg_v !== 7'h7E || dig_en !== 2'b01) begin
            n_fail++; $display("FAIL reset_dig0: seg=%h dig=%b want 7e/01", seg_v, dig_en);
        end
        wait_pos(12);
        n_checks++;
        if (seg_v !== 7'h7E || dig_en !== 2'b10) begin
            n_fail++; $display("FAIL reset_dig1: seg=%h dig=%b want 7e/10", seg_v, dig_en);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            dv   = ($urandom_range(0, 11) == 0);
            data = 8'($urandom);
            if ($urandom_range(0, 59) == 0) lz = ~lz;
            if ($urandom_range(0, 149) == 0) en = ~en;
            rst  = ($urandom_range(0, 499) == 0);
            tick();
            n_checks++;
            if (actual_v() !== expected_v()) begin
                n_fail++; $display("FAIL random cyc %0d: got %h want %h", i, actual_v(), expected_v());
            end
        end
        dv = 1'b0; rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_mid_frame_load();
        test_boundary_collision();
        test_lz_blank();
        test_disable();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
